mux_nx1_stream: RTL and testbench
=================================

// Module: mux_nx1_stream
// PURPOSE
//  Parametrised N-to-1 stream multiplexer with registered output and
//  valid/ready handshake. It replaces combinational 3:1 select muxes where
//  the consumer can stall, e.g. writeback/forwarding sources or bus masters
//  sharing one port. Channel choice is either explicit (i_sel) or round-robin.
//  A single output register holds each beat until the consumer accepts it.
// PARAMETERS
//  DATA_WIDTH  32  width of each channel data word
//  NUM_CH      3   number of input channels, 2..16
//  RR_MODE     0   0: channel = i_sel; 1: round-robin among valid channels
//  SEL_W       $clog2(NUM_CH)  localparam, select/channel-id width
// PORTS
//  i_clk       in   1                  clock, rising edge
//  i_rst_n     in   1                  async active-low reset
//  i_sel       in   SEL_W              channel select, used only when RR_MODE=0
//  i_data      in   NUM_CH*DATA_WIDTH  channel k data is [k*DATA_WIDTH +: DATA_WIDTH]
//  i_valid     in   NUM_CH             per-channel valid
//  o_in_ready  out  NUM_CH             per-channel ready, one-hot or zero
//  o_data      out  DATA_WIDTH         registered output data
//  o_ch        out  SEL_W              channel id of beat in o_data
//  o_valid     out  1                  output register holds a beat
//  i_ready     in   1                  consumer accepts when o_valid & i_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): o_valid=0, o_data=0, o_ch=0,
//    rr pointer=NUM_CH-1, so channel 0 has first priority after reset.
//  - space = ~o_valid | i_ready; space allows a new capture in the same
//    cycle as an output accept, giving full throughput with no bubble.
//  - Grant g is computed combinationally each cycle:
//    RR_MODE=0: g=i_sel if i_sel<NUM_CH, else g=0 (same default as mux_3x1).
//    RR_MODE=1: g is the first k with i_valid[k], searching ptr+1, ptr+2, ...
//    and wrapping mod NUM_CH. If no channel is valid, there is no grant.
//  - o_in_ready[g]=space, all other bits are 0. o_in_ready does not depend on
//    i_valid in RR_MODE=0. In RR_MODE=1 it is all-zero with no grant.
//  - Transfer in: i_valid[g] & o_in_ready[g]. On the next edge, o_data is set
//    to the channel g word, o_ch=g, and o_valid=1. In RR_MODE=1, ptr is also
//    set to g. The ptr changes only on transfer in.
//  - Output accept without transfer in: o_valid goes to 0. o_data and o_ch
//    keep their last values.
//  - Stall (o_valid & ~i_ready): o_data, o_ch and o_valid hold stable, and
//    o_in_ready is all-zero. Changes on i_sel or i_valid during a stall have
//    no effect on the held beat.
//  - Latency is 1 cycle from input transfer to o_valid. There is no
//    combinational path from i_data to o_data.
//  - Reset mid-transfer discards the held beat. No partial state survives.
//  - No data is ever dropped or duplicated. Every input transfer yields
//    exactly one output accept.
// TESTING
//  T1 reset: assert i_rst_n=0 mid-stream -> o_valid=0, o_data=0, o_ch=0
//     immediately, without a clock edge.
//  T2 RR_MODE=0, NUM_CH=3, i_sel=1, i_valid=3'b111, i_data ch1=32'hA5A5_0001,
//     i_ready=1 -> next cycle o_data=32'hA5A5_0001, o_ch=1, o_in_ready=3'b010.
//     Repeat with i_sel=2'b11 -> channel 0 is granted.
//  T3 back-pressure: hold i_ready=0 for 4 cycles with o_valid=1 ->
//     o_data/o_ch stable, o_in_ready=0. Raise i_ready -> one accept, and a
//     new beat is captured in the same cycle (no bubble).
//  T4 RR_MODE=1, NUM_CH=4, all valid, i_ready=1 -> grants 0,1,2,3,0 on
//     consecutive cycles. Then i_valid=4'b1010 with ptr=1 -> grant 3, then 1.
//  T5 random: random valid/ready/sel for 10k cycles, with a scoreboard
//     per channel -> in-order, lossless, no duplicates. Check that
//     o_in_ready is one-hot or zero every cycle.

Source files
------------

// File: rtl/mux_nx1_stream_if.sv
// Stream bundle for mux_nx1_stream.
// Carries the N input channels (select, data, valid, ready back) and the single
// registered output channel (data, channel id, valid, ready in).
//   master : the surrounding producers/consumer; drives i_*, observes o_*
//   slave  : the multiplexer itself; observes i_*, drives o_*
interface mux_nx1_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 3
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0]             i_sel;
  logic [NUM_CH*DATA_WIDTH-1:0] i_data;
  logic [NUM_CH-1:0]            i_valid;
  logic [NUM_CH-1:0]            o_in_ready;
  logic [DATA_WIDTH-1:0]        o_data;
  logic [SEL_W-1:0]             o_ch;
  logic                         o_valid;
  logic                         i_ready;

  modport master (
    output i_sel, i_data, i_valid, i_ready,
    input  o_in_ready, o_data, o_ch, o_valid
  );

  modport slave (
    input  i_sel, i_data, i_valid, i_ready,
    output o_in_ready, o_data, o_ch, o_valid
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-to-1 stream multiplexer with a single registered output stage.
// Channel choice is explicit (i_sel) when RR_MODE=0, or round-robin among the
// valid channels when RR_MODE=1. The output register holds each beat until the
// consumer takes it; a new beat may be captured in the same cycle as an accept.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      slave side of mux_nx1_stream_if:
//              i_sel, i_data, i_valid, i_ready in;
//              o_in_ready, o_data, o_ch, o_valid out
module mux_nx1_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 3,
  parameter bit          RR_MODE    = 1'b0
) (
  input logic                i_clk,
  input logic                i_rst_n,
  mux_nx1_stream_if.slave    bus
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0]      ch_q,    ch_d;
  // Last granted channel; the search for the next grant starts just after it.
  logic [SEL_W-1:0]      ptr_q,   ptr_d;

  logic                  space;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic [NUM_CH-1:0]     in_ready;
  logic                  xfer_in;
  logic                  accept_out;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Register is free if empty, or if its beat leaves this cycle.
  assign space      = ~valid_q | bus.i_ready;
  assign accept_out = valid_q & bus.i_ready;

  always_comb begin : p_grant
    int unsigned      idx;
    logic [SEL_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    if (RR_MODE) begin
      // First valid channel at ptr+1, ptr+2, ... wrapping; ptr itself is last.
      for (int unsigned off = 1; off <= NUM_CH; off++) begin
        idx  = (32'(ptr_q) + off) % NUM_CH;
        cand = SEL_W'(idx);
        if (!grant_vld && bus.i_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end else begin
      // Out-of-range selects fall back to channel 0.
      grant_vld = 1'b1;
      if (32'(bus.i_sel) < NUM_CH) begin
        grant_idx = bus.i_sel;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld) begin
      in_ready[grant_idx] = space;
    end
  end

  assign xfer_in = grant_vld & bus.i_valid[grant_idx] & space;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer_in) begin
      valid_d = 1'b1;
      data_d  = ch_data[grant_idx];
      ch_d    = grant_idx;
      if (RR_MODE) begin
        ptr_d = grant_idx;
      end
    end else if (accept_out) begin
      // Data and channel id are left as-is; only the valid flag drops.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= SEL_W'(NUM_CH - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_ch       = ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: one fixed-select instance (3 channels) and one
// round-robin instance (4 channels), directed tables plus a random run against
// a per-channel scoreboard.
module tb_mux_nx1_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned N0 = 3;
  localparam int unsigned N1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nx1_stream_if #(.DATA_WIDTH(DW), .NUM_CH(N0)) bus0 ();
  mux_nx1_stream_if #(.DATA_WIDTH(DW), .NUM_CH(N1)) bus1 ();

  mux_nx1_stream #(.DATA_WIDTH(DW), .NUM_CH(N0), .RR_MODE(1'b0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  mux_nx1_stream #(.DATA_WIDTH(DW), .NUM_CH(N1), .RR_MODE(1'b1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed tables ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  valid;
    logic        ready;
    logic [2:0]  exp_rdy;
    logic        exp_v;
    logic [31:0] exp_data;
    logic [1:0]  exp_ch;
  } vec0_t;

  typedef struct {
    logic [3:0]  valid;
    logic        ready;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [31:0] exp_data;
    logic [1:0]  exp_ch;
  } vec1_t;

  vec0_t tab0 [11];
  vec1_t tab1 [12];

  // ---------------- random-phase model ----------------
  logic        hold [2];
  int          ptr  [2];
  int          seq  [8];
  logic [31:0] sb   [8][$];

  function automatic logic [31:0] word(input int d, input int k);
    return {8'(d * 16 + k), 24'(seq[d*4+k])};
  endfunction

  // Granted channel by the selection rules, or -1 when nothing is granted.
  function automatic int exp_grant(input int rr, input int n, input int sel,
                                   input logic [3:0] vld, input int p);
    if (rr == 0) return (sel < n) ? sel : 0;
    for (int off = 1; off <= n; off++) begin
      int c;
      c = (p + off) % n;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_cycle(input int d, input int n, input int rr, input int sel,
                             input logic [3:0] vld, input logic rdy,
                             input logic [3:0] in_rdy, input logic ov,
                             input logic [31:0] od, input logic [1:0] och);
    int         g;
    logic       sp;
    logic [3:0] exp_rdy;
    logic       nxt;
    g       = exp_grant(rr, n, sel, vld, ptr[d]);
    sp      = !hold[d] || rdy;
    exp_rdy = (g >= 0 && sp) ? 4'(1 << g) : 4'd0;
    check($sformatf("rnd%0d in_ready", d), 64'(in_rdy), 64'(exp_rdy));
    check($sformatf("rnd%0d onehot", d), 64'($countones(in_rdy) <= 1), 64'd1);
    check($sformatf("rnd%0d o_valid", d), 64'(ov), 64'(hold[d]));
    nxt = hold[d];
    if (hold[d] && rdy) begin
      nxt = 1'b0;
      checks++;
      if (int'(och) >= n || sb[d*4+int'(och)].size() == 0) begin
        errors++;
        $display("FAIL rnd%0d accept: got beat %0h on ch %0d expected no beat pending there",
                 d, od, och);
      end else begin
        logic [31:0] e;
        e = sb[d*4+int'(och)].pop_front();
        if (od !== e) begin
          errors++;
          $display("FAIL rnd%0d data: got %0h expected %0h", d, od, e);
        end
      end
    end
    if (g >= 0 && sp && vld[g]) begin
      sb[d*4+g].push_back(word(d, g));
      seq[d*4+g]++;
      nxt = 1'b1;
      if (rr != 0) ptr[d] = g;
    end
    hold[d] = nxt;
  endtask

  task automatic drive_data();
    for (int k = 0; k < int'(N0); k++) bus0.i_data[k*DW +: DW] = word(0, k);
    for (int k = 0; k < int'(N1); k++) bus1.i_data[k*DW +: DW] = word(1, k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tab0[0]  = '{2'd1, 3'b111, 1'b1, 3'b010, 1'b1, 32'hA5A5_0001, 2'd1};
    tab0[1]  = '{2'd3, 3'b111, 1'b1, 3'b001, 1'b1, 32'h1111_0000, 2'd0};
    tab0[2]  = '{2'd2, 3'b000, 1'b1, 3'b100, 1'b0, 32'h1111_0000, 2'd0};
    tab0[3]  = '{2'd2, 3'b100, 1'b0, 3'b100, 1'b1, 32'h2222_0002, 2'd2};
    tab0[4]  = '{2'd0, 3'b111, 1'b0, 3'b000, 1'b1, 32'h2222_0002, 2'd2};
    tab0[5]  = '{2'd1, 3'b010, 1'b0, 3'b000, 1'b1, 32'h2222_0002, 2'd2};
    tab0[6]  = '{2'd1, 3'b000, 1'b0, 3'b000, 1'b1, 32'h2222_0002, 2'd2};
    tab0[7]  = '{2'd3, 3'b001, 1'b0, 3'b000, 1'b1, 32'h2222_0002, 2'd2};
    tab0[8]  = '{2'd1, 3'b010, 1'b1, 3'b010, 1'b1, 32'hA5A5_0001, 2'd1};
    tab0[9]  = '{2'd0, 3'b110, 1'b1, 3'b001, 1'b0, 32'hA5A5_0001, 2'd1};
    tab0[10] = '{2'd3, 3'b000, 1'b0, 3'b001, 1'b0, 32'hA5A5_0001, 2'd1};

    tab1[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'hC0DE_0000, 2'd0};
    tab1[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hC0DE_0001, 2'd1};
    tab1[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'hC0DE_0002, 2'd2};
    tab1[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'hC0DE_0003, 2'd3};
    tab1[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'hC0DE_0000, 2'd0};
    tab1[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hC0DE_0001, 2'd1};
    tab1[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 32'hC0DE_0003, 2'd3};
    tab1[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'hC0DE_0001, 2'd1};
    tab1[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'hC0DE_0001, 2'd1};
    tab1[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 32'hC0DE_0002, 2'd2};
    tab1[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 32'hC0DE_0002, 2'd2};
    tab1[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'hC0DE_0000, 2'd0};

    rst_n         = 1'b0;
    bus0.i_sel    = '0;
    bus0.i_valid  = '0;
    bus0.i_ready  = 1'b1;
    bus0.i_data   = {32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
    bus1.i_sel    = '0;
    bus1.i_valid  = '0;
    bus1.i_ready  = 1'b1;
    bus1.i_data   = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    #12;
    check("reset0 o_valid", 64'(bus0.o_valid), 64'd0);
    check("reset0 o_data", 64'(bus0.o_data), 64'd0);
    check("reset1 o_valid", 64'(bus1.o_valid), 64'd0);
    check("reset1 o_in_ready", 64'(bus1.o_in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed-select table: grant, default select, stall and same-cycle refill.
    for (int i = 0; i < 11; i++) begin
      bus0.i_sel   = tab0[i].sel;
      bus0.i_valid = tab0[i].valid;
      bus0.i_ready = tab0[i].ready;
      #1;
      check($sformatf("t0[%0d] in_ready", i), 64'(bus0.o_in_ready), 64'(tab0[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("t0[%0d] o_valid", i), 64'(bus0.o_valid), 64'(tab0[i].exp_v));
      check($sformatf("t0[%0d] o_data", i), 64'(bus0.o_data), 64'(tab0[i].exp_data));
      check($sformatf("t0[%0d] o_ch", i), 64'(bus0.o_ch), 64'(tab0[i].exp_ch));
    end

    // Reset asserted while both instances hold a beat clears them with no edge.
    bus0.i_sel   = 2'd2;
    bus0.i_valid = 3'b100;
    bus0.i_ready = 1'b0;
    bus1.i_valid = 4'b1111;
    bus1.i_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset0 o_valid", 64'(bus0.o_valid), 64'd1);
    check("pre-reset1 o_valid", 64'(bus1.o_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset0 o_valid", 64'(bus0.o_valid), 64'd0);
    check("midreset0 o_data", 64'(bus0.o_data), 64'd0);
    check("midreset0 o_ch", 64'(bus0.o_ch), 64'd0);
    check("midreset1 o_valid", 64'(bus1.o_valid), 64'd0);
    check("midreset1 o_data", 64'(bus1.o_data), 64'd0);
    bus0.i_valid = '0;
    bus0.i_ready = 1'b1;
    bus1.i_valid = '0;
    bus1.i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin table, starting from the post-reset pointer.
    for (int i = 0; i < 12; i++) begin
      bus1.i_valid = tab1[i].valid;
      bus1.i_ready = tab1[i].ready;
      #1;
      check($sformatf("t1[%0d] in_ready", i), 64'(bus1.o_in_ready), 64'(tab1[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("t1[%0d] o_valid", i), 64'(bus1.o_valid), 64'(tab1[i].exp_v));
      check($sformatf("t1[%0d] o_data", i), 64'(bus1.o_data), 64'(tab1[i].exp_data));
      check($sformatf("t1[%0d] o_ch", i), 64'(bus1.o_ch), 64'(tab1[i].exp_ch));
    end

    // Random run on both instances against the scoreboard.
    bus0.i_valid = '0;
    bus1.i_valid = '0;
    bus0.i_ready = 1'b1;
    bus1.i_ready = 1'b1;
    do_reset();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    ptr[0]  = int'(N0) - 1;
    ptr[1]  = int'(N1) - 1;
    for (int i = 0; i < 8; i++) seq[i] = 0;

    for (int cyc = 0; cyc < 10010; cyc++) begin
      if (cyc < 10000) begin
        bus0.i_sel   = 2'($urandom_range(0, 3));
        bus0.i_valid = 3'($urandom_range(0, 7));
        bus0.i_ready = ($urandom_range(0, 3) != 0);
        bus1.i_sel   = 2'($urandom_range(0, 3));
        bus1.i_valid = 4'($urandom_range(0, 15));
        bus1.i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus0.i_valid = '0;
        bus0.i_ready = 1'b1;
        bus1.i_valid = '0;
        bus1.i_ready = 1'b1;
      end
      drive_data();
      #1;
      model_cycle(0, int'(N0), 0, int'(bus0.i_sel), {1'b0, bus0.i_valid}, bus0.i_ready,
                  {1'b0, bus0.o_in_ready}, bus0.o_valid, bus0.o_data, bus0.o_ch);
      model_cycle(1, int'(N1), 1, int'(bus1.i_sel), bus1.i_valid, bus1.i_ready,
                  bus1.o_in_ready, bus1.o_valid, bus1.o_data, bus1.o_ch);
      @(posedge clk);
      #1;
    end

    for (int d = 0; d < 2; d++) begin
      int left;
      left = 0;
      for (int k = 0; k < 4; k++) left += sb[d*4+k].size();
      check($sformatf("drain%0d pending", d), 64'(left), 64'd0);
    end
    check("drain0 o_valid", 64'(bus0.o_valid), 64'd0);
    check("drain1 o_valid", 64'(bus1.o_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
